// File: rtl/inst_block_mem.sv
// Block-read instruction memory: serves 4-word (128-bit) blocks to the instruction
// cache over a read/busy/valid handshake, with a word-wide preload write port.
module inst_block_mem #(
    parameter int LATENCY = 4,
    parameter int WORDS   = 256
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         read,
    input  logic [5:0]   block_addr,
    output logic         busy,
    output logic         valid,
    output logic [127:0] block_data,
    input  logic         wr_en,
    input  logic [7:0]   wr_addr,
    input  logic [31:0]  wr_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    logic [31:0]  mem_r [WORDS];
    state_t       state_r;
    state_t       state_next_s;
    logic [7:0]   cnt_r;
    logic [7:0]   cnt_next_s;
    logic [5:0]   addr_r;
    logic [5:0]   addr_next_s;
    logic         busy_next_s;
    logic         valid_next_s;
    logic         load_s;
    logic [127:0] rd_block_s;

    // Preload write port; the array is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Block gather from the latched address; base is a multiple of 4 so it never wraps.
    always_comb begin
        rd_block_s = {mem_r[{addr_r, 2'b11}], mem_r[{addr_r, 2'b10}],
                      mem_r[{addr_r, 2'b01}], mem_r[{addr_r, 2'b00}]};
    end

    // Next-state and next-output logic for the request handshake.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        addr_next_s  = addr_r;
        busy_next_s  = 1'b0;
        valid_next_s = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (read) begin
                    state_next_s = ST_WAIT;
                    cnt_next_s   = CNT_LOAD;
                    addr_next_s  = block_addr;
                    busy_next_s  = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 8'd0) begin
                    state_next_s = ST_HOLD;
                    valid_next_s = 1'b1;
                    load_s       = 1'b1;
                end else begin
                    cnt_next_s  = cnt_r - 8'd1;
                    busy_next_s = 1'b1;
                end
            end
            ST_HOLD: begin
                // One response per read assertion: wait for read to drop.
                if (read) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            addr_r     <= 6'd0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            block_data <= 128'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            addr_r  <= addr_next_s;
            busy    <= busy_next_s;
            valid   <= valid_next_s;
            if (load_s) begin
                block_data <= rd_block_s;
            end
        end
    end

endmodule

// File: tb/tb_inst_block_mem.sv
// Self-checking bench for inst_block_mem: LATENCY=4 and LATENCY=1 instances,
// returned blocks checked against a scoreboard queue when valid strobes.
module tb_inst_block_mem;

    logic         clk;
    logic         rst;
    logic         wr_en;
    logic [7:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         rd0;
    logic [5:0]   addr0;
    logic         busy0;
    logic         valid0;
    logic [127:0] data0;
    logic         rd1;
    logic [5:0]   addr1;
    logic         busy1;
    logic         valid1;
    logic [127:0] data1;

    int checks = 0;
    int errors = 0;
    logic [127:0] q0[$];
    logic [127:0] q1[$];
    logic [127:0] exp_blk;

    inst_block_mem #(.LATENCY(4)) dut0 (
        .CLK(clk), .RESET(rst), .read(rd0), .block_addr(addr0),
        .busy(busy0), .valid(valid0), .block_data(data0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    inst_block_mem #(.LATENCY(1)) dut1 (
        .CLK(clk), .RESET(rst), .read(rd1), .block_addr(addr1),
        .busy(busy1), .valid(valid1), .block_data(data1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every valid strobe must match the oldest expected block.
    always @(negedge clk) begin
        if (valid0) begin
            checks = checks + 1;
            if (q0.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb0_unexpected_valid: got data %h, required no valid", data0);
            end else begin
                exp_blk = q0.pop_front();
                if (data0 !== exp_blk) begin
                    errors = errors + 1;
                    $display("FAIL sb0_block: got %h, required %h", data0, exp_blk);
                end
            end
        end
        if (valid1) begin
            checks = checks + 1;
            if (q1.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb1_unexpected_valid: got data %h, required no valid", data1);
            end else begin
                exp_blk = q1.pop_front();
                if (data1 !== exp_blk) begin
                    errors = errors + 1;
                    $display("FAIL sb1_block: got %h, required %h", data1, exp_blk);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [7:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        checks = checks + 4;
        if (busy0 !== 1'b0) begin errors = errors + 1; $display("FAIL reset_busy: got %b, required 0", busy0); end
        if (valid0 !== 1'b0) begin errors = errors + 1; $display("FAIL reset_valid: got %b, required 0", valid0); end
        if (data0 !== 128'd0) begin errors = errors + 1; $display("FAIL reset_data: got %h, required 0", data0); end
        if (busy1 !== 1'b0 || valid1 !== 1'b0) begin
            errors = errors + 1; $display("FAIL reset_dut1: got busy %b valid %b, required 0 0", busy1, valid1);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_read();
        wr_word(8'd4, 32'h11);
        wr_word(8'd5, 32'h22);
        wr_word(8'd6, 32'h33);
        wr_word(8'd7, 32'h44);
        for (int i = 0; i < 4; i++) wr_word(8'(252 + i), 32'hA0 + 32'(i));
        rd0   = 1'b1;
        addr0 = 6'd1;
        q0.push_back({32'h44, 32'h33, 32'h22, 32'h11});
        for (int e = 0; e < 4; e++) begin
            tick();
            checks = checks + 1;
            if (busy0 !== 1'b1 || valid0 !== 1'b0) begin
                errors = errors + 1;
                $display("FAIL basic_busy_E%0d: got busy %b valid %b, required 1 0", e, busy0, valid0);
            end
        end
        tick();
        checks = checks + 1;
        if (valid0 !== 1'b1 || busy0 !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL basic_data_edge: got busy %b valid %b, required 0 1", busy0, valid0);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks = checks + 1;
            if (valid0 !== 1'b0 || busy0 !== 1'b0) begin
                errors = errors + 1;
                $display("FAIL basic_hold_%0d: got busy %b valid %b, required 0 0", i, busy0, valid0);
            end
        end
        rd0 = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        rd0   = 1'b1;
        addr0 = 6'd1;
        q0.push_back({32'h44, 32'h33, 32'h22, 32'h11});
        tick();
        addr0 = 6'd2;
        for (int e = 1; e < 4; e++) tick();
        tick();
        checks = checks + 1;
        if (valid0 !== 1'b1) begin
            errors = errors + 1; $display("FAIL b2b_first_valid: got %b, required 1", valid0);
        end
        rd0 = 1'b0;
        tick();
        rd0   = 1'b1;
        addr0 = 6'd63;
        q0.push_back({32'hA3, 32'hA2, 32'hA1, 32'hA0});
        tick();
        checks = checks + 1;
        if (busy0 !== 1'b1) begin
            errors = errors + 1; $display("FAIL b2b_second_accept: got busy %b, required 1", busy0);
        end
        for (int e = 1; e < 4; e++) tick();
        tick();
        checks = checks + 1;
        if (valid0 !== 1'b1 || busy0 !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL b2b_second_valid: got busy %b valid %b, required 0 1", busy0, valid0);
        end
        rd0 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_write_during_wait();
        rd0   = 1'b1;
        addr0 = 6'd1;
        q0.push_back({32'h44, 32'h33, 32'hBEEF, 32'h11});
        tick();
        tick();
        wr_word(8'd5, 32'hBEEF);
        tick();
        wr_word(8'd6, 32'hCAFE);
        checks = checks + 1;
        if (valid0 !== 1'b1) begin
            errors = errors + 1; $display("FAIL wr_wait_valid: got %b, required 1", valid0);
        end
        rd0 = 1'b0;
        tick();
        rd0 = 1'b1;
        q0.push_back({32'h44, 32'hCAFE, 32'hBEEF, 32'h11});
        for (int e = 0; e <= 4; e++) tick();
        checks = checks + 1;
        if (valid0 !== 1'b1) begin
            errors = errors + 1; $display("FAIL wr_reread_valid: got %b, required 1", valid0);
        end
        rd0 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_request();
        rd0   = 1'b1;
        addr0 = 6'd63;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks = checks + 1;
        if (busy0 !== 1'b0 || valid0 !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL midreset_abort: got busy %b valid %b, required 0 0", busy0, valid0);
        end
        rd0 = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks = checks + 1;
            if (valid0 !== 1'b0 || busy0 !== 1'b0) begin
                errors = errors + 1;
                $display("FAIL midreset_quiet_%0d: got busy %b valid %b, required 0 0", i, busy0, valid0);
            end
        end
        rd0 = 1'b1;
        q0.push_back({32'hA3, 32'hA2, 32'hA1, 32'hA0});
        for (int e = 0; e <= 4; e++) tick();
        checks = checks + 1;
        if (valid0 !== 1'b1) begin
            errors = errors + 1; $display("FAIL midreset_reread_valid: got %b, required 1", valid0);
        end
        rd0 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_latency_one();
        rd1   = 1'b1;
        addr1 = 6'd1;
        q1.push_back({32'h44, 32'hCAFE, 32'hBEEF, 32'h11});
        tick();
        checks = checks + 1;
        if (busy1 !== 1'b1 || valid1 !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL lat1_E0: got busy %b valid %b, required 1 0", busy1, valid1);
        end
        tick();
        checks = checks + 1;
        if (busy1 !== 1'b0 || valid1 !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL lat1_E1: got busy %b valid %b, required 0 1", busy1, valid1);
        end
        tick();
        checks = checks + 1;
        if (valid1 !== 1'b0) begin
            errors = errors + 1; $display("FAIL lat1_single_pulse: got %b, required 0", valid1);
        end
        rd1 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 8'd0;
        wr_data = 32'd0;
        rd0     = 1'b0;
        addr0   = 6'd0;
        rd1     = 1'b0;
        addr1   = 6'd0;
        test_reset();
        test_basic_read();
        test_back_to_back();
        test_write_during_wait();
        test_reset_mid_request();
        test_latency_one();
        checks = checks + 2;
        if (q0.size() != 0) begin
            errors = errors + 1; $display("FAIL sb0_leftover: got %0d pending, required 0", q0.size());
        end
        if (q1.size() != 0) begin
            errors = errors + 1; $display("FAIL sb1_leftover: got %0d pending, required 0", q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
